// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and its surroundings.
// The master side is the supervisor; the slave side is the PLL and reset tree.
interface pll_lock_supervisor_if #(
   parameter int RETRY_W = 8
);
   logic               locked;
   logic               clr_flags;
   logic               pll_rst;
   logic               sys_rst_n;
   logic               pll_ok;
   logic               lock_lost;
   logic [RETRY_W-1:0] retry_count;

   modport master (
      input  locked, clr_flags,
      output pll_rst, sys_rst_n, pll_ok, lock_lost, retry_count
   );

   modport slave (
      output locked, clr_flags,
      input  pll_rst, sys_rst_n, pll_ok, lock_lost, retry_count
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies its lock output and releases downstream reset
// only after lock has been continuously stable; re-resets the PLL on timeout or loss.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int CNT_W               = 16,
   parameter int RETRY_W             = 8
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   pll_lock_supervisor_if.master  bus
);

   typedef enum logic [1:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN
   } state_e;

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   locked_s;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pll_rst_q, pll_rst_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic                   pll_ok_q, pll_ok_d;
   logic                   lock_lost_q, lock_lost_d;
   logic [RETRY_W-1:0]     retry_count_q, retry_count_d;

   logic                   lost_set;
   logic                   retry_set;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.locked};
   assign locked_s = sync_q[SYNC_STAGES-1];

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lost_set  = 1'b0;
      retry_set = 1'b0;

      unique case (state_q)
         S_PLL_RST: begin
            if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d   = S_PLL_RST;
               retry_set = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STABLE: begin
            if (!locked_s)                 state_d = S_WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = S_RUN;
            else                           cnt_d   = cnt_q + 1'b1;
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d  = S_PLL_RST;
               lost_set = 1'b1;
            end
         end
         default: state_d = S_PLL_RST;
      endcase

      // Every transition changes state, so a state change is exactly a state entry.
      if (state_d != state_q) cnt_d = '0;

      // Outputs follow the next state so they change on the edge that enters it.
      pll_rst_d   = (state_d == S_PLL_RST);
      sys_rst_n_d = (state_d == S_RUN);
      pll_ok_d    = (state_d == S_RUN);

      // A set event on the same edge as clr_flags takes priority over the clear.
      lock_lost_d = lost_set | (lock_lost_q & ~bus.clr_flags);

      if (retry_set)
         retry_count_d = (retry_count_q == RETRY_MAX) ? retry_count_q : retry_count_q + 1'b1;
      else if (bus.clr_flags)
         retry_count_d = '0;
      else
         retry_count_d = retry_count_q;
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= '0;
         state_q       <= S_PLL_RST;
         cnt_q         <= '0;
         pll_rst_q     <= 1'b1;
         sys_rst_n_q   <= 1'b0;
         pll_ok_q      <= 1'b0;
         lock_lost_q   <= 1'b0;
         retry_count_q <= '0;
      end else begin
         sync_q        <= sync_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pll_rst_q     <= pll_rst_d;
         sys_rst_n_q   <= sys_rst_n_d;
         pll_ok_q      <= pll_ok_d;
         lock_lost_q   <= lock_lost_d;
         retry_count_q <= retry_count_d;
      end
   end

   assign bus.pll_rst     = pll_rst_q;
   assign bus.sys_rst_n   = sys_rst_n_q;
   assign bus.pll_ok      = pll_ok_q;
   assign bus.lock_lost   = lock_lost_q;
   assign bus.retry_count = retry_count_q;

endmodule
